// File: rtl/seqdet_pkg.sv
// Shared types and default pattern for the bit-serial sequence detector.
package seqdet_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
   localparam int             PAT_W_DEF = 4;
   localparam logic [3:0]     PAT_DEF   = 4'b0111;
endpackage

// File: rtl/seqdet_scheduler_if.sv
// Word-in / result-out handshake bundle between producer, scheduler and consumer.
interface seqdet_scheduler_if #(parameter int WORD_W = 8);
   localparam int CW = $clog2(WORD_W + 1);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              res_valid;
   logic              res_ready;
   logic [CW-1:0]     res_count;

   modport master (output in_valid, in_data, res_ready,
                   input  in_ready, res_valid, res_count);
   modport slave  (input  in_valid, in_data, res_ready,
                   output in_ready, res_valid, res_count);
endinterface

// File: rtl/seqdet_match.sv
// Serial pattern matcher: sliding history plus fill guard, hit is combinational on the current bit.
module seqdet_match
   import seqdet_pkg::*;
#(
   parameter int               PAT_W = PAT_W_DEF,
   parameter logic [PAT_W-1:0] PAT   = PAT_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic bit_vld,
   input  logic bit_in,
   output logic hit
);
   localparam int FW = $clog2(PAT_W);

   logic [PAT_W-2:0] r_hist;
   logic [FW-1:0]    r_fill;
   logic [PAT_W-1:0] w_win;
   logic             w_full;

   assign w_win  = {r_hist, bit_in};
   assign w_full = (r_fill == FW'(PAT_W - 1));
   assign hit    = bit_vld && w_full && (w_win == PAT);

   // Fill only counts up to PAT_W-1; beyond that the history is always meaningful.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (bit_vld) begin
         r_hist <= w_win[PAT_W-2:0];
         if (!w_full) r_fill <= r_fill + FW'(1);
      end
   end
endmodule

// File: rtl/seqdet_scheduler.sv
// Word-to-bit scheduler around seqdet_match; per-word and saturating total match counts.
// Optional SEQDET_IRQ_EN adds a sticky threshold interrupt on total_count.
module seqdet_scheduler
   import seqdet_pkg::*;
#(
   parameter int               WORD_W = 8,
   parameter int               PAT_W  = PAT_W_DEF,
   parameter logic [PAT_W-1:0] PAT    = PAT_DEF,
   parameter int               CNT_W  = 16
`ifdef SEQDET_IRQ_EN
   , parameter int             IRQ_TH = 16
`endif
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   seqdet_scheduler_if.slave bus,
   output logic [CNT_W-1:0] total_count,
   output logic             busy
`ifdef SEQDET_IRQ_EN
   , output logic           irq
`endif
);
   localparam int CW = $clog2(WORD_W + 1);
   localparam int IW = $clog2(WORD_W);

   state_t            r_state, w_next;
   logic [WORD_W-1:0] r_shreg;
   logic [IW-1:0]     r_bit_idx;
   logic [CW-1:0]     r_word_cnt;
   logic [CNT_W-1:0]  r_total;
   logic              w_accept, w_bit_vld, w_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)        w_next = SHIFT;
         SHIFT:   if (r_bit_idx == '0)     w_next = REPORT;
         REPORT:  if (bus.res_ready)       w_next = IDLE;
         default:                          w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == IDLE);
      bus.res_valid = (r_state == REPORT);
      busy          = (r_state != IDLE);
      w_bit_vld     = (r_state == SHIFT);
   end

   assign w_accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bit_idx <= '0;
      end else if (w_accept) begin
         r_shreg   <= bus.in_data;
         r_bit_idx <= IW'(WORD_W - 1);
      end else if (w_bit_vld) begin
         r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
         r_bit_idx <= r_bit_idx - IW'(1);
      end
   end

   seqdet_match #(.PAT_W(PAT_W), .PAT(PAT)) u_match (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .bit_vld (w_bit_vld),
      .bit_in  (r_shreg[WORD_W-1]),
      .hit     (w_hit)
   );

   // clear wins over a hit in the same cycle; the total never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_cnt <= '0;
         r_total    <= '0;
      end else if (clear) begin
         r_word_cnt <= '0;
         r_total    <= '0;
      end else begin
         if (w_accept)   r_word_cnt <= '0;
         else if (w_hit) r_word_cnt <= r_word_cnt + CW'(1);
         if (w_hit && (r_total != '1)) r_total <= r_total + CNT_W'(1);
      end
   end

   assign bus.res_count = r_word_cnt;
   assign total_count   = r_total;

`ifdef SEQDET_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        irq <= 1'b0;
      else if (clear) irq <= 1'b0;
      else if (int'(r_total) >= IRQ_TH) irq <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_seqdet_scheduler.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks each result handshake.
module tb_seqdet_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic res_ready = 1'b1;
   logic [15:0] total_m;
   logic [1:0]  total_s;
   logic busy_m, busy_s;
`ifdef SEQDET_IRQ_EN
   logic irq_m, irq_s;
`endif

   typedef struct {
      int cnt;
      int tot;
      int stot;
   } exp_t;
   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seqdet_scheduler_if #(.WORD_W(8)) bus  ();
   seqdet_scheduler_if #(.WORD_W(8)) bus2 ();

   assign bus.in_valid   = in_valid;
   assign bus.in_data    = in_data;
   assign bus.res_ready  = res_ready;
   assign bus2.in_valid  = in_valid;
   assign bus2.in_data   = in_data;
   assign bus2.res_ready = res_ready;

   seqdet_scheduler #(.WORD_W(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus),
      .total_count(total_m), .busy(busy_m)
`ifdef SEQDET_IRQ_EN
      , .irq(irq_m)
`endif
   );

   seqdet_scheduler #(.WORD_W(8), .CNT_W(2)
`ifdef SEQDET_IRQ_EN
      , .IRQ_TH(3)
`endif
   ) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus2),
      .total_count(total_s), .busy(busy_s)
`ifdef SEQDET_IRQ_EN
      , .irq(irq_s)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a result handshake completes on the posedge after this sample.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("res_count",   int'(bus.res_count), e.cnt);
               chk("total_count", int'(total_m),       e.tot);
               chk("sat_total",   int'(total_s),       e.stot);
               chk("sat_res_valid", int'(bus2.res_valid), 1);
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; clear = 1'b0; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Returns 1 ns after the accepting edge.
   task automatic send(input logic [7:0] d, input int cnt, input int tot, input bit push);
      int n = 0;
      exp_t e;
      if (push) begin
         e.cnt = cnt; e.tot = tot; e.stot = (tot > 3) ? 3 : tot;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("accept_timeout", 0, 1);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy_m) && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      int k;
      do_reset();
      @(negedge clk);
      chk("rst_in_ready",  int'(bus.in_ready), 1);
      chk("rst_res_valid", int'(bus.res_valid), 0);
      chk("rst_busy",      int'(busy_m), 0);
      chk("rst_total",     int'(total_m), 0);
      chk("rst_res_count", int'(bus.res_count), 0);

      // 0111_0111: two hits, result 8 edges after accept
      send(8'h77, 2, 2, 1);
      for (k = 1; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.res_valid) break;
      end
      chk("res_latency", k, 8);
      wait_idle();

      // fill guard, then a match from history carried into the next word
      do_reset();
      send(8'hE0, 0, 0, 1);
      send(8'h0F, 1, 1, 1);
      wait_idle();

      // cross-word carry
      do_reset();
      send(8'h01, 0, 0, 1);
      send(8'hC0, 1, 1, 1);
      wait_idle();

      // backpressure with a waiting word
      do_reset();
      res_ready = 1'b0;
      send(8'h77, 2, 2, 1);
      k = 0;
      while (!bus.res_valid && k < 50) begin @(posedge clk); #1; k++; end
      if (k >= 50) chk("res_valid_timeout", 0, 1);
      begin
         exp_t e;
         e.cnt = 0; e.tot = 2; e.stot = 2;
         exp_q.push_back(e);
      end
      in_valid = 1'b1; in_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_res_valid", int'(bus.res_valid), 1);
         chk("bp_res_count", int'(bus.res_count), 2);
         chk("bp_in_ready",  int'(bus.in_ready), 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
      @(posedge clk); #1 in_valid = 1'b0;
      wait_idle();

      // saturation on the narrow counter, then clear
      do_reset();
      send(8'h77, 2, 2, 1);
      send(8'h77, 2, 4, 1);
      send(8'h77, 2, 6, 1);
      send(8'h77, 2, 8, 1);
      wait_idle();
      chk("sat_hold", int'(total_s), 3);
`ifdef SEQDET_IRQ_EN
      chk("irq_set",     int'(irq_s), 1);
      chk("irq_main_lo", int'(irq_m), 0);
`endif
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      chk("clear_total",     int'(total_m), 0);
      chk("clear_sat_total", int'(total_s), 0);
`ifdef SEQDET_IRQ_EN
      chk("irq_cleared", int'(irq_s), 0);
`endif

      // reset in the 4th shift cycle drops the word
      do_reset();
      send(8'h77, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_res_valid", int'(bus.res_valid), 0);
      chk("midrst_in_ready",  int'(bus.in_ready), 1);
      chk("midrst_busy",      int'(busy_m), 0);
      chk("midrst_total",     int'(total_m), 0);
      chk("midrst_res_count", int'(bus.res_count), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      send(8'h70, 1, 1, 1);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
